axi_lite_rr_arbiter: RTL and testbench
======================================

Name: axi_lite_rr_arbiter

Overview:
- Transaction-level round-robin scheduler for the shared AXI4-Lite interconnect path.
- Picks one master and one transaction type (read or write) at a time and holds the grant until the response handshake completes.
- Enforces a watchdog timeout so a stalled slave cannot lock the bus.
- Its grant outputs drive the master-side mux select and read/write routing of the interconnect datapath.

Parameters:
- NUM_MASTER, 2, number of requesting masters (>= 2).
- TIMEOUT_CYCLES, 256, cycles allowed in READ/WRITE before abort; 0 disables the watchdog.
- IDXW, $clog2(NUM_MASTER), width of grant index (derived, not overridden).

Ports:
- aclk  in  1  clock, all state on rising edge.
- areset_n  in  1  reset, asynchronous, active-low.
- arvalid_i  in  NUM_MASTER  per-master ARVALID.
- awvalid_i  in  NUM_MASTER  per-master AWVALID.
- rvalid_i  in  1  RVALID of the currently routed slave.
- rready_i  in  1  RREADY of the currently granted master.
- bvalid_i  in  1  BVALID of the currently routed slave.
- bready_i  in  1  BREADY of the currently granted master.
- grant_o  out  NUM_MASTER  one-hot grant, all-zero when idle.
- grant_idx_o  out  IDXW  index of the granted master (holds last value when idle).
- rd_active_o  out  1  granted transaction is a read.
- wr_active_o  out  1  granted transaction is a write.
- timeout_o  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (async assert, sync release): state=IDLE, grant_o=0, grant_idx_o=0, rd/wr_active_o=0, timeout_o=0, rr pointer=NUM_MASTER-1 so master 0 wins first, last_op=WRITE, counter=0.
- States: IDLE, READ, WRITE. All outputs are registered, with no combinational path from inputs to outputs.
- Request vector: req[i] = arvalid_i[i] | awvalid_i[i].
- IDLE, any req set:
  - Winner = first set bit scanning ptr+1, ptr+2, ... modulo NUM_MASTER.
  - If the winner has only arvalid set, go to READ; if only awvalid, go to WRITE.
  - If the winner has both, take the opposite of last_op (alternation).
  - On the same edge: grant_o/grant_idx_o/rd|wr_active_o are set, ptr=winner, last_op=chosen type, counter cleared.
- Grant latency: a request sampled at edge n makes the grant visible after edge n. The arbiter never grants in the same cycle as the request.
- READ: completes on an edge where rvalid_i & rready_i. WRITE: completes on bvalid_i & bready_i. On completion, go to IDLE and clear grant/active on that edge.
- Back-to-back grants: at least one IDLE cycle between grants, so the interconnect select is stable when VALID is forwarded.
- Grant stability: grant_o, grant_idx_o and the op type are constant for the whole READ/WRITE state. Deassertion of the granted master's valid does not release the grant; only completion or timeout does.
- Watchdog (TIMEOUT_CYCLES>0):
  - Counter increments each cycle in READ/WRITE, saturating at TIMEOUT_CYCLES.
  - If the counter equals TIMEOUT_CYCLES-1 and completion is absent this cycle, then next edge: timeout_o=1 for one cycle, state=IDLE, grant cleared. ptr still points to the aborted master, so it gets lowest priority next round.
  - Completion on the same cycle the limit is reached takes precedence: normal completion, no timeout_o.
- Completion-type responses in the wrong state (rvalid in WRITE, bvalid in READ, either in IDLE) are ignored.
- Reset asserted mid-transaction: immediate return to reset values regardless of clock.
- Width: counter width = $clog2(TIMEOUT_CYCLES+1), minimum 1. The pointer wraps from NUM_MASTER-1 to 0.

Test Plan:
- Reset then arvalid_i=2'b11 held, rvalid/rready high 3 cycles after each grant -> grants alternate M0, M1, M0, ...; grant_o 01 then 10; one IDLE cycle between grants.
- M0 awvalid and arvalid both high continuously, completion after 2 cycles each -> rd_active_o and wr_active_o alternate, starting with READ (last_op reset=WRITE).
- Single M1 write, bvalid_i=1 with bready_i=0 for 5 cycles then bready_i=1 -> grant_o=10 held for all 6 cycles, released on the edge after the handshake.
- TIMEOUT_CYCLES=8, M0 read, rvalid_i never asserted -> timeout_o pulses once exactly 8 cycles after grant; next arvalid_i=2'b11 grants M1 first.
- TIMEOUT_CYCLES=8, rvalid_i&rready_i in the 8th grant cycle -> normal completion, timeout_o stays 0.
- areset_n pulsed low asynchronously (between clock edges) during WRITE -> grant_o=0 and wr_active_o=0 immediately; after release with awvalid_i=2'b10, M1 is granted.

Source files
------------

// File: rtl/axi_lite_rr_arbiter_if.sv
// ----------------------------------------------------------------------------
// axi_lite_rr_arbiter_if
//   Bundles the request valids, routed response handshakes and grant outputs
//   of the AXI4-Lite round-robin arbiter.
//
//   arvalid_i / awvalid_i  per-master read / write address valids
//   rvalid_i / rready_i    R-channel handshake of the currently routed path
//   bvalid_i / bready_i    B-channel handshake of the currently routed path
//   grant_o                one-hot grant, all-zero when idle
//   grant_idx_o            index of the granted master (holds when idle)
//   rd_active_o            granted transaction is a read
//   wr_active_o            granted transaction is a write
//   timeout_o              one-cycle pulse on watchdog abort
//
//   Modports: slave  = arbiter side (consumes requests, produces grants)
//             master = requester / interconnect side
// ----------------------------------------------------------------------------
interface axi_lite_rr_arbiter_if #(
  parameter int NUM_MASTER = 2,
  parameter int IDXW       = $clog2(NUM_MASTER)
);
  logic [NUM_MASTER-1:0] arvalid_i;
  logic [NUM_MASTER-1:0] awvalid_i;
  logic                  rvalid_i;
  logic                  rready_i;
  logic                  bvalid_i;
  logic                  bready_i;
  logic [NUM_MASTER-1:0] grant_o;
  logic [IDXW-1:0]       grant_idx_o;
  logic                  rd_active_o;
  logic                  wr_active_o;
  logic                  timeout_o;

  modport slave (
    input  arvalid_i, awvalid_i, rvalid_i, rready_i, bvalid_i, bready_i,
    output grant_o, grant_idx_o, rd_active_o, wr_active_o, timeout_o
  );

  modport master (
    output arvalid_i, awvalid_i, rvalid_i, rready_i, bvalid_i, bready_i,
    input  grant_o, grant_idx_o, rd_active_o, wr_active_o, timeout_o
  );
endinterface

// File: rtl/axi_lite_rr_arbiter.sv
// ----------------------------------------------------------------------------
// axi_lite_rr_arbiter
//   Transaction-level round-robin scheduler for a shared AXI4-Lite path.
//   Grants one master and one transaction type at a time and holds the grant
//   until the matching response handshake completes, or until the watchdog
//   aborts a stalled transaction.
//
//   aclk      clock, all state on the rising edge
//   areset_n  asynchronous active-low reset
//   bus       axi_lite_rr_arbiter_if.slave (requests in, grants out)
//
//   All outputs are registered: a request sampled on one edge is granted on
//   that edge and becomes visible after it, and at least one IDLE cycle
//   separates consecutive grants so the datapath select settles first.
// ----------------------------------------------------------------------------
module axi_lite_rr_arbiter #(
  parameter int NUM_MASTER     = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 aclk,
  input  logic                 areset_n,
  axi_lite_rr_arbiter_if.slave bus
);

  localparam int IDXW = $clog2(NUM_MASTER);
  localparam int CW   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  state_e                state_q;
  op_e                   last_op_q;
  logic [IDXW-1:0]       ptr_q;
  logic [CW-1:0]         cnt_q;
  logic [NUM_MASTER-1:0] grant_q;
  logic [IDXW-1:0]       grant_idx_q;
  logic                  rd_active_q;
  logic                  wr_active_q;
  logic                  timeout_q;

  logic [NUM_MASTER-1:0] req;
  logic                  found;
  logic [IDXW-1:0]       win_idx;
  logic [IDXW-1:0]       cand_idx;
  logic                  win_rd;
  logic                  done;
  int                    cand;

  // Winner search: first requester after the pointer, wrapping around, so
  // the most recently served master has the lowest priority.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch;
    // a path that leaves one unassigned would infer a latch.
    req      = bus.arvalid_i | bus.awvalid_i;
    found    = 1'b0;
    win_idx  = '0;
    cand_idx = '0;
    cand     = 0;
    for (int off = 1; off <= NUM_MASTER; off++) begin
      cand     = (int'(ptr_q) + off) % NUM_MASTER;
      cand_idx = IDXW'(cand);
      if (!found && req[cand_idx]) begin
        found   = 1'b1;
        win_idx = cand_idx;
      end
    end

    // A master asking for both types alternates against the last served op.
    if (bus.arvalid_i[win_idx] && bus.awvalid_i[win_idx]) begin
      win_rd = (last_op_q == OP_WRITE);
    end else begin
      win_rd = bus.arvalid_i[win_idx];
    end

    // Responses of the other type (or any response while idle) are ignored.
    done = ((state_q == ST_READ)  && bus.rvalid_i && bus.rready_i) ||
           ((state_q == ST_WRITE) && bus.bvalid_i && bus.bready_i);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      // NOTE: only control state is reset; there is no storage array here.
      // Pointer starts at the last master so master 0 wins the first round.
      state_q     <= ST_IDLE;
      last_op_q   <= OP_WRITE;
      ptr_q       <= IDXW'(NUM_MASTER - 1);
      cnt_q       <= '0;
      grant_q     <= '0;
      grant_idx_q <= '0;
      rd_active_q <= 1'b0;
      wr_active_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (found) begin
            state_q     <= win_rd ? ST_READ : ST_WRITE;
            last_op_q   <= win_rd ? OP_READ : OP_WRITE;
            ptr_q       <= win_idx;
            cnt_q       <= '0;
            grant_q     <= NUM_MASTER'(1) << win_idx;
            grant_idx_q <= win_idx;
            rd_active_q <= win_rd;
            wr_active_q <= !win_rd;
          end
        end

        ST_READ, ST_WRITE: begin
          if (done) begin
            // Completion wins even on the cycle the watchdog limit is hit.
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            rd_active_q <= 1'b0;
            wr_active_q <= 1'b0;
          end else if ((TIMEOUT_CYCLES > 0) && (cnt_q == CNT_LAST)) begin
            // Abort; the pointer stays on the aborted master so it drops to
            // lowest priority next round.
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            rd_active_q <= 1'b0;
            wr_active_q <= 1'b0;
            timeout_q   <= 1'b1;
          end else if ((TIMEOUT_CYCLES > 0) && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          grant_q     <= '0;
          rd_active_q <= 1'b0;
          wr_active_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant_o     = grant_q;
  assign bus.grant_idx_o = grant_idx_q;
  assign bus.rd_active_o = rd_active_q;
  assign bus.wr_active_o = wr_active_q;
  assign bus.timeout_o   = timeout_q;

endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_axi_lite_rr_arbiter
//   Self-checking bench for axi_lite_rr_arbiter (2 masters, watchdog of 8).
//   Inputs change 1 time unit after a rising edge; outputs are sampled there
//   too, i.e. they reflect the edge just taken.
// ----------------------------------------------------------------------------
module tb_axi_lite_rr_arbiter;

  localparam int N  = 2;
  localparam int TO = 8;

  logic aclk;
  logic areset_n;

  axi_lite_rr_arbiter_if #(.NUM_MASTER(N)) bus ();

  axi_lite_rr_arbiter #(
    .NUM_MASTER     (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .aclk     (aclk),
    .areset_n (areset_n),
    .bus      (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_vec = 0;
  int n_err = 0;

  // resp = {rvalid, rready, bvalid, bready}
  typedef struct packed {
    logic [1:0] ar;
    logic [1:0] aw;
    logic [3:0] resp;
    logic [1:0] g;
    logic       idx;
    logic       rd;
    logic       wr;
    logic       to;
  } vec_t;

  vec_t vecs [18];

  // Behavioural reference: who owns the bus, for how many cycles, what type.
  bit busy;
  int owner;
  bit is_read;
  int age;
  int rr_last;
  bit last_was_read;
  bit to_pulse;
  int last_owner;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [1:0] g, input logic idx,
                            input logic rd, input logic wr, input logic to);
    check({tag, ".grant"},   32'(bus.grant_o),     32'(g));
    check({tag, ".idx"},     32'(bus.grant_idx_o), 32'(idx));
    check({tag, ".rd"},      32'(bus.rd_active_o), 32'(rd));
    check({tag, ".wr"},      32'(bus.wr_active_o), 32'(wr));
    check({tag, ".timeout"}, 32'(bus.timeout_o),   32'(to));
  endtask

  task automatic drive(input logic [1:0] ar, input logic [1:0] aw, input logic [3:0] resp);
    bus.arvalid_i = ar;
    bus.awvalid_i = aw;
    bus.rvalid_i  = resp[3];
    bus.rready_i  = resp[2];
    bus.bvalid_i  = resp[1];
    bus.bready_i  = resp[0];
  endtask

  task automatic step(input logic [1:0] ar, input logic [1:0] aw, input logic [3:0] resp);
    drive(ar, aw, resp);
    @(posedge aclk);
    #1;
  endtask

  // Reset pulse placed between clock edges.
  task automatic do_reset();
    @(negedge aclk);
    drive(2'b00, 2'b00, 4'b0000);
    areset_n = 1'b0;
    #2;
    areset_n = 1'b1;
  endtask

  task automatic model_reset();
    busy          = 1'b0;
    owner         = 0;
    is_read       = 1'b0;
    age           = 0;
    rr_last       = N - 1;
    last_was_read = 1'b0;
    to_pulse      = 1'b0;
    last_owner    = 0;
  endtask

  // Advance the reference by one edge given the inputs seen at that edge.
  task automatic model_step(input logic [1:0] ar, input logic [1:0] aw, input logic [3:0] resp);
    bit finished;
    bit picked;
    int m;
    to_pulse = 1'b0;
    picked   = 1'b0;
    if (!busy) begin
      for (int k = 1; k <= N; k++) begin
        m = (rr_last + k) % N;
        if (!picked && (ar[m] || aw[m])) begin
          picked        = 1'b1;
          is_read       = (ar[m] && aw[m]) ? !last_was_read : ar[m];
          busy          = 1'b1;
          owner         = m;
          rr_last       = m;
          last_owner    = m;
          last_was_read = is_read;
          age           = 0;
        end
      end
    end else begin
      age++;
      finished = is_read ? (resp[3] && resp[2]) : (resp[1] && resp[0]);
      if (finished) begin
        busy = 1'b0;
      end else if (age == TO) begin
        busy     = 1'b0;
        to_pulse = 1'b1;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [1:0] exp_g;
    logic [1:0] r_ar;
    logic [1:0] r_aw;
    logic [3:0] r_resp;

    //            ar     aw     resp     grant  idx   rd    wr    to
    vecs[0]  = '{2'b11, 2'b00, 4'b0000, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{2'b11, 2'b00, 4'b0011, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{2'b11, 2'b00, 4'b1000, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{2'b11, 2'b00, 4'b1100, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{2'b11, 2'b00, 4'b0000, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{2'b00, 2'b00, 4'b0000, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{2'b00, 2'b00, 4'b1100, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{2'b00, 2'b00, 4'b1111, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{2'b11, 2'b00, 4'b0000, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{2'b11, 2'b00, 4'b1100, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{2'b11, 2'b00, 4'b0000, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{2'b00, 2'b10, 4'b0000, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{2'b00, 2'b10, 4'b1100, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{2'b00, 2'b10, 4'b0000, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{2'b00, 2'b10, 4'b1100, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{2'b00, 2'b00, 4'b0011, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{2'b01, 2'b00, 4'b0000, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[17] = '{2'b00, 2'b00, 4'b1100, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state, observed while reset is still asserted.
    areset_n = 1'b0;
    drive(2'b00, 2'b00, 4'b0000);
    #12;
    check_outs("reset", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    areset_n = 1'b1;

    // Table: round-robin alternation, holds, ignored responses.
    for (int i = 0; i < 18; i++) begin
      step(vecs[i].ar, vecs[i].aw, vecs[i].resp);
      check_outs($sformatf("vec%0d", i), vecs[i].g, vecs[i].idx,
                 vecs[i].rd, vecs[i].wr, vecs[i].to);
    end

    // Master 0 asks for both types: READ first after reset, then alternate.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(2'b01, 2'b01, 4'b0000);
      check_outs($sformatf("alt%0d.grant", k), 2'b01, 1'b0, (k % 2) == 0, (k % 2) == 1, 1'b0);
      step(2'b01, 2'b01, 4'b0000);
      check_outs($sformatf("alt%0d.hold", k), 2'b01, 1'b0, (k % 2) == 0, (k % 2) == 1, 1'b0);
      step(2'b01, 2'b01, ((k % 2) == 0) ? 4'b1100 : 4'b0011);
      check_outs($sformatf("alt%0d.done", k), 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Master 1 write, BVALID stalled by BREADY low for 5 cycles.
    step(2'b00, 2'b10, 4'b0000);
    check_outs("bstall.grant", 2'b10, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(2'b00, 2'b00, 4'b0010);
      check_outs($sformatf("bstall.hold%0d", k), 2'b10, 1'b1, 1'b0, 1'b1, 1'b0);
    end
    step(2'b00, 2'b00, 4'b0011);
    check_outs("bstall.done", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);

    // Master 0 read never answered: abort exactly 8 cycles after the grant.
    step(2'b01, 2'b00, 4'b0000);
    check_outs("wd.grant", 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= TO; k++) begin
      step(2'b00, 2'b00, 4'b0000);
      if (k < TO) check_outs($sformatf("wd.wait%0d", k), 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
      else        check_outs("wd.abort", 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    step(2'b11, 2'b00, 4'b0000);
    check_outs("wd.next_m1", 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
    step(2'b00, 2'b00, 4'b1100);
    check_outs("wd.next_done", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);

    // Completion on the last allowed cycle beats the watchdog.
    step(2'b01, 2'b00, 4'b0000);
    check_outs("edge.grant", 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= TO; k++) begin
      if (k < TO) begin
        step(2'b00, 2'b00, 4'b0000);
        check_outs($sformatf("edge.wait%0d", k), 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
      end else begin
        step(2'b00, 2'b00, 4'b1100);
        check_outs("edge.done", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end
    step(2'b00, 2'b00, 4'b0000);
    check_outs("edge.after", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a write.
    step(2'b00, 2'b01, 4'b0000);
    check_outs("arst.grant", 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    areset_n = 1'b0;
    #1;
    check_outs("arst.async", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    areset_n = 1'b1;
    step(2'b00, 2'b10, 4'b0000);
    check_outs("arst.after", 2'b10, 1'b1, 1'b0, 1'b1, 1'b0);
    step(2'b00, 2'b00, 4'b0011);
    check_outs("arst.done", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);

    // Random traffic against the reference.
    do_reset();
    model_reset();
    for (int c = 0; c < 800; c++) begin
      r_ar   = 2'($urandom_range(0, 3));
      r_aw   = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      r_resp = 4'($urandom_range(0, 15));
      model_step(r_ar, r_aw, r_resp);
      step(r_ar, r_aw, r_resp);
      exp_g = busy ? 2'(1 << owner) : 2'b00;
      check_outs($sformatf("rnd%0d", c), exp_g, 1'(last_owner),
                 busy && is_read, busy && !is_read, to_pulse);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
